// File: rtl/aes_128_decryption_axil_regs_if.sv
// AXI4-Lite bus bundle between the IP's S00_AXI master and the AES-128 decryption register file.
interface aes_128_decryption_axil_regs_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                      awprot;
  logic                            awvalid;
  logic                            awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                            wvalid;
  logic                            wready;
  logic [1:0]                      bresp;
  logic                            bvalid;
  logic                            bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
  logic [2:0]                      arprot;
  logic                            arvalid;
  logic                            arready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                      rresp;
  logic                            rvalid;
  logic                            rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/aes_128_decryption_axil_regs.sv
// AXI4-Lite register file for the AES-128 decryption core: key/ciphertext in, start/status control,
// plaintext capture on completion.
module aes_128_decryption_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                                ACLK,
  input  logic                                ARESETN,
  aes_128_decryption_axil_regs_if.slave       S_AXI,
  output logic [127:0]                        aes_key,
  output logic [127:0]                        aes_ct,
  output logic                                aes_start,
  input  logic                                aes_done,
  input  logic [127:0]                        aes_pt
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam logic [3:0] SLOT_CTRL     = 4'd8;
  localparam logic [3:0] SLOT_STATUS   = 4'd9;
  localparam logic [3:0] SLOT_UNMAPPED = 4'd14;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;

  logic            rst_done;
  logic            aw_held;
  logic            w_held;
  logic [3:0]      aw_slot;
  logic [DW-1:0]   w_data;
  logic [DW/8-1:0] w_strb;
  logic            bvalid_q;
  logic [1:0]      bresp_q;
  logic            rvalid_q;
  logic [1:0]      rresp_q;
  logic [DW-1:0]   rdata_q;
  logic [DW-1:0]   key_r [4];
  logic [DW-1:0]   ct_r  [4];
  logic [DW-1:0]   pt_r  [4];
  logic            busy;
  logic            done;
  logic            start_ign;
  logic            start_q;

  // Ready lines stay low until the first edge after reset release.
  assign S_AXI.awready = rst_done & ~aw_held & ~bvalid_q;
  assign S_AXI.wready  = rst_done & ~w_held & ~bvalid_q;
  assign S_AXI.arready = rst_done & ~rvalid_q;
  assign S_AXI.bvalid  = bvalid_q;
  assign S_AXI.bresp   = bresp_q;
  assign S_AXI.rvalid  = rvalid_q;
  assign S_AXI.rresp   = rresp_q;
  assign S_AXI.rdata   = rdata_q;

  assign aes_key   = {key_r[0], key_r[1], key_r[2], key_r[3]};
  assign aes_ct    = {ct_r[0], ct_r[1], ct_r[2], ct_r[3]};
  assign aes_start = start_q;

  logic commit, slot_kc, wr_err, ctrl_wr, start_req, clr_req, done_hit, start_ok;
  assign commit    = aw_held & w_held;
  assign slot_kc   = (aw_slot < SLOT_CTRL);
  assign wr_err    = (aw_slot >= SLOT_UNMAPPED) | (slot_kc & busy);
  assign ctrl_wr   = commit & (aw_slot == SLOT_CTRL) & w_strb[0];
  assign start_req = ctrl_wr & w_data[0];
  assign clr_req   = ctrl_wr & w_data[1];
  assign done_hit  = aes_done & busy;
  // A completion landing on the same edge frees the core before the new start is judged.
  assign start_ok  = start_req & ~(busy & ~aes_done);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rst_done <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_slot  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      rst_done <= 1'b1;
      if (S_AXI.awvalid && S_AXI.awready) begin
        aw_held <= 1'b1;
        aw_slot <= S_AXI.awaddr[5:2];
      end
      if (S_AXI.wvalid && S_AXI.wready) begin
        w_held <= 1'b1;
        w_data <= S_AXI.wdata;
        w_strb <= S_AXI.wstrb;
      end
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && S_AXI.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) begin
        key_r[i] <= '0;
        ct_r[i]  <= '0;
      end
    end else if (commit && slot_kc && !busy) begin
      for (int b = 0; b < DW/8; b++) begin
        if (w_strb[b]) begin
          if (!aw_slot[2]) key_r[aw_slot[1:0]][b*8 +: 8] <= w_data[b*8 +: 8];
          else             ct_r[aw_slot[1:0]][b*8 +: 8]  <= w_data[b*8 +: 8];
        end
      end
    end
  end

  // Later assignments win: completion, then CLR_DONE, then START.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      start_ign <= 1'b0;
      start_q   <= 1'b0;
      for (int i = 0; i < 4; i++) pt_r[i] <= '0;
    end else begin
      start_q <= start_ok;
      if (done_hit) begin
        for (int i = 0; i < 4; i++) pt_r[i] <= aes_pt[(3-i)*DW +: DW];
        busy <= 1'b0;
        done <= 1'b1;
      end
      if (clr_req) begin
        done      <= 1'b0;
        start_ign <= 1'b0;
      end
      if (start_ok) begin
        busy <= 1'b1;
        done <= 1'b0;
      end else if (start_req) begin
        start_ign <= 1'b1;
      end
    end
  end

  logic [3:0]    rd_slot;
  logic [1:0]    pt_sel;
  logic [DW-1:0] rd_data;
  assign rd_slot = S_AXI.araddr[5:2];
  assign pt_sel  = rd_slot[1:0] + 2'd2;

  always_comb begin
    rd_data = '0;
    if (rd_slot < 4'd4)                            rd_data = key_r[rd_slot[1:0]];
    else if (rd_slot < SLOT_CTRL)                  rd_data = ct_r[rd_slot[1:0]];
    else if (rd_slot == SLOT_STATUS)               rd_data = {{(DW-3){1'b0}}, start_ign, done, busy};
    else if (rd_slot > SLOT_STATUS && rd_slot < SLOT_UNMAPPED) rd_data = pt_r[pt_sel];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else if (S_AXI.arvalid && S_AXI.arready) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= (rd_slot >= SLOT_UNMAPPED) ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid_q && S_AXI.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{S_AXI.awprot, S_AXI.arprot, S_AXI.awaddr[1:0], S_AXI.araddr[1:0]};
endmodule
